muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide responder for the RV32 datapath, implementing the full M-extension operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). The ALU and control path raise a start request with two register operands and a funct3-coded op. The unit then computes over a fixed 33-cycle latency and returns a registered 32-bit result with a one-cycle done pulse. It replaces single-cycle combinational `*`, `/` and `%` paths, so that timing closes at the target clock.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32 M-extension multiply/divide unit.
// Accepts a request when idle. The request is computed as 32 shift-add
// (multiply) or restoring (divide) steps. Sign correction follows in one
// FINISH cycle. Fixed latency of 33 cycles from acceptance to done.
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   start, op[2:0]       request strobe and funct3 op code (sampled when !busy)
//   operand_a/operand_b  rs1 / rs2 values, captured at acceptance
//   busy                 operation in flight
//   done                 one-cycle pulse, result valid
//   result               registered result, held until the next done
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] ma;     // |a|: multiplicand, or dividend shifted out MSB-first
  logic [XLEN-1:0] mb;     // |b|: multiplier shifted LSB-first, or divisor
  logic [2*XLEN-1:0] acc;  // product, or {remainder, quotient}
  logic [CW-1:0]   cnt;
  logic            neg_p, neg_q, neg_r;

  // Operand signedness by op code
  logic a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && operand_a[XLEN-1];
    b_neg    = b_signed && operand_b[XLEN-1];
    abs_a    = a_neg ? -operand_a : operand_a;
    abs_b    = b_neg ? -operand_b : operand_b;
  end

  // One iteration of each algorithm
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (mb[0] ? {1'b0, ma} : '0);
    div_sh  = {acc[2*XLEN-1:XLEN], ma[XLEN-1]};
    div_ge  = div_sh >= {1'b0, mb};
    // When div_ge holds the difference fits XLEN bits
    div_rem = div_ge ? (div_sh[XLEN-1:0] - mb) : div_sh[XLEN-1:0];
  end

  // Sign correction and word select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, sel;
  always_comb begin
    prod = neg_p ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 sel = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel = quo;
      default:                sel = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          ma    <= abs_a;
          mb    <= abs_b;
          neg_p <= a_neg ^ b_neg;
          // Divide by zero leaves the all-ones quotient unnegated
          neg_q <= (a_neg ^ b_neg) && (operand_b != '0);
          neg_r <= a_neg;
          acc   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          if (!op_q[2]) begin
            acc <= {mul_sum, acc[XLEN-1:1]};
            mb  <= mb >> 1;
          end else begin
            acc <= {div_rem, acc[XLEN-2:0], div_ge};
            ma  <= ma << 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER-1)) state <= FINISH;
        end
        FINISH: begin
          result <= sel;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec vectors, handshake
// corner cases, mid-operation reset and randomized ops against an
// arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 0, rst = 1, start = 0;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0, failures = 0;

  muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .op(op),
                   .operand_a(a), .operand_b(b),
                   .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'b0, x}); uy = longint'({32'b0, y});
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: if (y == 0) return 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
            else return 32'($signed(x) / $signed(y));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: if (y == 0) return x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            else return 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request at the negedge; returns #1 after the acceptance edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Counts edges until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done && lat < 40);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    issue(o, x, y);
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, " lat"}, 32'(lat), 32'd33);
    check({tag, " res"}, result, model(o, x, y));
    @(posedge clk); #1;
    check({tag, " pulse"}, {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] x, y, r0;
    logic [2:0] o;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst state", {busy, done, 30'b0} | result, 32'd0);
    @(negedge clk); rst = 0;

    // Spec vectors, sanity of model constants too
    check("model mul", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run("mul",    3'd0, 32'd7, 32'hFFFF_FFFD);
    run("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD);
    run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    run("div",    3'd4, 32'hFFFF_FFF9, 32'd2);
    run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2);
    run("divu",   3'd5, 32'd100, 32'd7);
    run("remu",   3'd7, 32'd100, 32'd7);
    run("divu0",  3'd5, 32'h1234_5678, 32'd0);
    run("rem0",   3'd6, 32'h1234_5678, 32'd0);
    run("div0n",  3'd4, 32'hFFFF_FFF9, 32'd0);
    run("rem0n",  3'd6, 32'hFFFF_FFF9, 32'd0);
    run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check("exp divovf", result, 32'h0);

    // start during busy is ignored
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1; op = 3'd5; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 0;
    wait_done(lat);
    check("ign lat", 32'(lat), 32'd28);
    check("ign res", result, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    check("ign nodone", {31'b0, done | busy}, 32'd0);

    // Back-to-back: start in the done cycle
    issue(3'd5, 32'd100, 32'd7);
    wait_done(lat);
    check("b2b lat1", 32'(lat), 32'd33);
    check("b2b res1", result, 32'd14);
    start = 1; op = 3'd7; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 0;
    check("b2b accept", {30'b0, done, busy}, 32'd1);
    check("b2b hold", result, 32'd14);
    wait_done(lat);
    check("b2b lat2", 32'(lat), 32'd33);
    check("b2b res2", result, 32'd2);

    // Reset mid-DIV
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(posedge clk);
    #2; rst = 1; #1;
    check("midrst", {busy, done, 30'b0} | result, 32'd0);
    @(negedge clk); rst = 0;
    lat = 0;
    repeat (40) begin @(posedge clk); #1; if (done) lat++; end
    check("midrst nodone", 32'(lat), 32'd0);
    run("postrst", 3'd4, 32'hFFFF_FFF9, 32'd2);

    // Randomized with edge-biased operands
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom);
      case ($urandom_range(0, 5))
        0: x = 32'h8000_0000; 1: x = 32'hFFFF_FFFF; 2: x = 32'd0;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: y = 32'hFFFF_FFFF; 1: y = 32'd0; 2: y = $urandom_range(1, 15);
        default: y = $urandom;
      endcase
      issue(o, x, y);
      wait_done(lat);
      r0 = model(o, x, y);
      check($sformatf("rnd%0d lat", i), 32'(lat), 32'd33);
      check($sformatf("rnd%0d op%0d a=%h b=%h", i, o, x, y), result, r0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
